// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button debounce slice.
// Defaults match the simon game wrapper running at 20 MHz.
package btn_pkg;

    localparam int NUM_BTN_DEFAULT     = 4;
    localparam int DEBOUNCE_MS_DEFAULT = 10;
    localparam int SYNC_STAGES_DEFAULT = 2;

    localparam logic [15:0] TPM_20MHZ = 16'd20000;

    // Width of a counter that must hold 0..ms.
    function automatic int cnt_width(input int ms);
        return $clog2(ms + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw pads and tick rate in, clean levels,
// edge pulses and the ms strobe out.
interface btn_debounce_if
    import btn_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT
);

    logic [15:0]        ticks_per_milli;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_out;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] rel;
    logic               ms_tick;

    modport master (
        output ticks_per_milli,
        output btn_in,
        input  btn_out,
        input  press,
        input  rel,
        input  ms_tick
    );

    modport slave (
        input  ticks_per_milli,
        input  btn_in,
        output btn_out,
        output press,
        output rel,
        output ms_tick
    );

endinterface

// File: rtl/debounce_channel.sv
// One button: synchroniser, ms-window counter, stable level and
// registered press/release pulses.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEBOUNCE_MS);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic                   level_d;
    logic                   press_d;
    logic                   rel_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous pad input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Window logic: count ms ticks while the input disagrees with the
    // stable level; any return to the stable value restarts the window.
    always_comb begin
        cnt_d   = cnt;
        level_d = level;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync == level) begin
            cnt_d = '0;
        end else if (ms_tick) begin
            if (cnt == LAST) begin
                level_d = sync;
                cnt_d   = '0;
                press_d = sync;
                rel_d   = ~sync;
            end else begin
                cnt_d = cnt + CW'(1);
            end
        end
    end

    // Stable level, window counter and single-cycle pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            level <= level_d;
            press <= press_d;
            rel   <= rel_d;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Debounce front end for the simon core: shared ms prescaler plus
// one independent debounce channel per button.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int NUM_BTN     = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    btn_debounce_if.slave bus
);

    if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_ms
        $error("DEBOUNCE_MS out of range 1..255");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic [15:0]        pcnt;
    logic [15:0]        pmax;
    logic               ms_tick;
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] rel_w;

    // 0 and 1 both mean a tick every cycle.
    assign pmax = (bus.ticks_per_milli == 16'd0) ? 16'd0
                : bus.ticks_per_milli - 16'd1;

    // Prescaler; >= lets a lowered rate wrap at once instead of
    // running through the full 16-bit range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt    <= '0;
            ms_tick <= 1'b0;
        end else if (pcnt >= pmax) begin
            pcnt    <= '0;
            ms_tick <= 1'b1;
        end else begin
            pcnt    <= pcnt + 16'd1;
            ms_tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ms_tick (ms_tick),
            .btn_raw (bus.btn_in[i]),
            .level   (level_w[i]),
            .press   (press_w[i]),
            .rel     (rel_w[i])
        );
    end

    assign bus.btn_out = level_w;
    assign bus.press   = press_w;
    assign bus.rel     = rel_w;
    assign bus.ms_tick = ms_tick;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input conditioning stage directly upstream of the simon game core.
- Takes the four raw, asynchronous push-button pins (io_in[11:8]) and produces clean, glitch-free levels for the game's btn input.
- Also produces single-cycle press and release event pulses.
- The debounce window is set in milliseconds from the same ticks_per_milli value the game core uses, so one clock-rate setting drives both blocks.

Parameters:
- NUM_BTN, 4, number of button channels.
- DEBOUNCE_MS, 10, input must be stable for this many ms before the output changes. Legal range is 1..255.
- SYNC_STAGES, 2, number of synchroniser flops per channel. Minimum 2.

Ports:
- clk  input  1  system clock (wb_clk_i in the wrapper).
- rst  input  1  asynchronous active-high reset.
- ticks_per_milli  input  16  clk cycles per millisecond. Values 0 and 1 both mean one ms tick every cycle.
- btn_in  input  NUM_BTN  raw pad inputs, active-high (pressed = 1).
- btn_out  output  NUM_BTN  debounced level, drives simon btn.
- press  output  NUM_BTN  one-cycle pulse on each debounced 0->1 transition.
- release  output  NUM_BTN  one-cycle pulse on each debounced 1->0 transition.
- ms_tick  output  1  one-cycle ms strobe, exported for bench and LA observation.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high. All flops clear while rst=1.
  - btn_out=0, press=0, release=0, ms_tick=0.
  - Synchroniser flops, prescaler and all channel counters are cleared to 0.
- Prescaler (shared by all channels):
  - 16-bit counter pcnt.
  - Each cycle: if pcnt >= ticks_per_milli-1 (saturating at 0 when ticks_per_milli=0), then pcnt<=0 and ms_tick<=1. Otherwise pcnt<=pcnt+1 and ms_tick<=0.
  - After reset, the first ms_tick is asserted in cycle index tpm-1. The comparison is >=, so if ticks_per_milli drops mid-count the prescaler wraps on the next cycle and never locks up.
- Synchroniser: SYNC_STAGES flops per bit, reset to 0. sync[i] is btn_in[i] delayed by SYNC_STAGES cycles.
- Channel i (the debounce_channel instance):
  - State: stable (equals btn_out[i]) and counter cnt of width clog2(DEBOUNCE_MS+1).
  - If sync == stable: cnt<=0, outputs hold. Any bounce back to the stable value restarts the window.
  - If sync != stable and ms_tick=1:
    - If cnt == DEBOUNCE_MS-1: stable<=sync and cnt<=0. press<=sync (rising) or release<=~sync (falling) for exactly that one cycle.
    - Otherwise: cnt<=cnt+1.
  - If sync != stable and ms_tick=0: hold cnt.
  - press and release are registered and high for one cycle only. They are never both high on the same channel. They rise in the same cycle that btn_out changes.
- Latency from a clean edge at btn_in to the btn_out change: between SYNC_STAGES+(DEBOUNCE_MS-1)*tpm+1 and SYNC_STAGES+DEBOUNCE_MS*tpm cycles.
- Channels are fully independent. Simultaneous presses on several channels each produce their own pulse, possibly in the same cycle.
- A pulse shorter than the window (any length < DEBOUNCE_MS-1 ms) never reaches btn_out.
- Reset mid-window discards all partial counts. After reset, a button already held is reported as a fresh press after the full window.

Decomposition:
- Shared package btn_pkg holds:
  - NUM_BTN_DEFAULT=4.
  - DEBOUNCE_MS_DEFAULT=10.
  - TPM_20MHZ=20000.
  - A function cnt_width(ms) returning clog2(ms+1).
- Sub-module debounce_channel: one bit, containing the sync chain, counter, stable flop and pulse flops. It is instantiated NUM_BTN times via generate.
- The prescaler stays in the top level.

Test Plan (tpm=4, DEBOUNCE_MS=3, SYNC_STAGES=2 unless noted):
- Reset and prescaler: release rst at cycle 0 with btn_in=0 -> btn_out, press and release stay 0. ms_tick is high at cycles 3, 7, 11 and low otherwise.
- Clean press: btn_in[0]=1 at cycle 0 and held -> btn_out[0] rises within cycles 11..14. press[0] is high for exactly 1 cycle, coincident with the rise. release stays 0.
- Bounce rejection: btn_in[1] toggles 1/0 every 3 cycles for 40 cycles, then stays 0 -> btn_out[1], press[1] and release[1] remain 0 throughout.
- Release: after the press above, btn_in[0]=0 held -> btn_out[0] falls 11..14 cycles later. release[0] gives a single 1-cycle pulse and press[0]=0.
- Simultaneous channels plus tpm=0: ticks_per_milli=0, btn_in=4'b1111 at cycle 0 -> ms_tick is high every cycle. All btn_out bits rise together at cycle 2+3=5 with press=4'b1111 for one cycle.
- Reset mid-window: assert rst for 1 cycle after 2 ms of a held btn_in[2]=1 -> no pulse. btn_out[2] rises a full window (11..14 cycles) after rst deasserts.
